// File: rtl/mod_main_pkg.sv
//------------------------------------------------------------------------------
// mod_main_pkg
// Shared sizing constants and word/address types for the register-file block.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mod_main_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/sram_if_mem.sv
//------------------------------------------------------------------------------
// sram_if_mem
// Register-file storage: synchronous write, combinational read, synchronous clear.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_if_mem
    import mod_main_pkg::*;
#(
    parameter int ADDR_W = mod_main_pkg::ADDR_W,
    parameter int DATA_W = mod_main_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];

    // Clear has priority over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // No bypass of wdata_i: a same-address write is visible only after the edge.
    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/mod_main.sv
//------------------------------------------------------------------------------
// mod_main
// Externally accessible 16x32 register file behind an SRAM-style slave port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod_main
    import mod_main_pkg::*;
#(
    parameter int ADDR_W = mod_main_pkg::ADDR_W,
    parameter int DATA_W = mod_main_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic              s_wen,
    input  logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W-1:0] s_rdata
);

    // Slave port is wired straight through; an internal-access port can be muxed in here later.
    sram_if_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (s_addr),
        .wen_i   (s_wen),
        .wdata_i (s_wdata),
        .rdata_o (s_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mod_main.sv
//------------------------------------------------------------------------------
// tb_mod_main
// Self-checking bench acting as an SRAM master for mod_main.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_main;
    import mod_main_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    addr_t s_addr;
    logic  s_wen;
    data_t s_wdata;
    data_t s_rdata;

    mod_main #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_addr  (s_addr),
        .s_wen   (s_wen),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    r;
        bit    w;
        addr_t a;
        data_t d;
        data_t exp_after;
    } vec_t;

    data_t model [DEPTH];
    data_t exp_q [$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string nm);
        data_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", nm, s_rdata);
        end else begin
            e = exp_q.pop_front();
            if (s_rdata !== e) begin
                errors++;
                $display("FAIL %s: addr=%0d got %h expected %h", nm, s_addr, s_rdata, e);
            end
        end
    endtask

    // One cycle: inputs driven just after a posedge, read checked mid-cycle
    // (pre-edge value) and again just after the next posedge.
    task automatic drive(input bit r, input bit w, input addr_t a, input data_t d,
                         input data_t exp_after, input string nm);
        rst = r; s_wen = w; s_addr = a; s_wdata = d;
        exp_q.push_back(model[a]);
        @(negedge clk);
        check({nm, "_pre"});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (w) begin
            model[a] = d;
        end
        #1;
        exp_q.push_back(exp_after);
        check({nm, "_post"});
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'd7, 32'd5,         32'd5};
        vecs[1] = '{1'b0, 1'b1, 4'd8, 32'd6,         32'd6};
        vecs[2] = '{1'b0, 1'b0, 4'd7, 32'd0,         32'd5};
        vecs[3] = '{1'b0, 1'b0, 4'd8, 32'd0,         32'd6};
        vecs[4] = '{1'b0, 1'b1, 4'd3, 32'hDEADBEEF,  32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b0, 4'd3, 32'h0,         32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b0, 4'd0, 32'h0,         32'h0};

        rst = 1'b1; s_wen = 1'b1; s_addr = 4'd5; s_wdata = 32'h9;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; s_wen = 1'b0;

        // Reset state of every word
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b0, addr_t'(i), 32'hA5A5A5A5, 32'h0, "reset_read");

        // Table: consecutive-cycle reads and read-during-write on addr 3
        for (int i = 0; i < 7; i++)
            drive(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_after, "table");

        // Back-to-back writes across the full depth, then read-back for aliasing
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b1, addr_t'(i), 32'(i) * 32'h01010101, 32'(i) * 32'h01010101, "b2b_wr");
        for (int i = DEPTH - 1; i >= 0; i--)
            drive(1'b0, 1'b0, addr_t'(i), 32'h0, 32'(i) * 32'h01010101, "b2b_rd");

        // Reset wins over a simultaneous write
        drive(1'b0, 1'b1, 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, "pre_rst_wr15");
        drive(1'b0, 1'b1, 4'd0,  32'h1,        32'h1,        "pre_rst_wr0");
        drive(1'b1, 1'b1, 4'd5,  32'h9,        32'h0,        "rst_vs_wr");
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b0, addr_t'(i), 32'h0, 32'h0, "post_rst_rd");

        // s_wen=0 must leave memory untouched whatever addr/data do
        drive(1'b0, 1'b1, 4'd2, 32'h1234, 32'h1234, "wr2");
        for (int i = 0; i < 10; i++) begin
            addr_t a;
            a = addr_t'($urandom_range(0, DEPTH - 1));
            drive(1'b0, 1'b0, a, $urandom, (a == 4'd2) ? 32'h1234 : 32'h0, "wen0_rand");
        end
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b0, addr_t'(i), 32'hFFFF0000, (i == 2) ? 32'h1234 : 32'h0, "wen0_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mod_main.md
Name: mod_main

Overview:
- Top-level block containing a 16-word x 32-bit register-file memory.
- The memory is exposed to the outside through a simple SRAM-style slave port (s_*).
- Writes are synchronous and take effect at the next rising clock edge.
- Reads are asynchronous/combinational from the currently presented address.
- Used as the externally accessible storage of the generated design. It is exercised by a bench acting as an SRAM master.

Parameters:
- ADDR_W, 4, address width in bits; memory depth = 2**ADDR_W words (16).
- DATA_W, 32, data word width in bits.

Ports:
- clk      input   1       system clock; all state updates on rising edge
- rst      input   1       synchronous, active-high reset
- s_addr   input   ADDR_W  word address for both read and write
- s_wen    input   1       write enable; 1 = write s_wdata to s_addr at the clock edge
- s_wdata  input   DATA_W  write data
- s_rdata  output  DATA_W  read data = current contents of the word at s_addr (combinational)

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Storage: array of 2**ADDR_W words of DATA_W bits.
- Reset:
  - While rst=1 at a rising edge, every word is cleared to 0.
  - No write occurs during reset, even with s_wen=1.
  - After reset, s_rdata reads 0 for every address until that address is written.
- Write:
  - At a rising edge with rst=0 and s_wen=1, mem[s_addr] <= s_wdata.
  - No handshake and no stall: one write per cycle, back-to-back writes to any addresses are allowed.
- Read:
  - s_rdata = mem[s_addr] continuously, with zero-cycle latency from an address change.
  - A write performed at edge N is visible on s_rdata immediately after edge N whenever s_addr points to that word.
- Read-during-write, same address: before the edge s_rdata shows the old contents; after the edge it shows the new data. There is no write-through bypass of s_wdata.
- Consecutive-cycle read pattern: address A presented for one cycle, then address B. s_rdata must equal mem[A] at the edge that ends A's cycle, then mem[B] at the following edge.
- Address range: s_addr fully covers the depth, so there are no out-of-range addresses and no wrap handling is needed.
- s_wen=0: memory unchanged regardless of s_addr and s_wdata.
- Reset mid-operation: reset wins over a simultaneous write, and all contents are zeroed.
- X/undefined inputs are not required to be handled.

Decomposition:
- Shared package mod_main_pkg:
  - constants ADDR_W=4, DATA_W=32, DEPTH=16
  - typedefs addr_t, data_t
- One sub-module, sram_if_mem: the storage array with synchronous write, asynchronous read and synchronous clear.
- mod_main instantiates sram_if_mem and wires the s_* port straight through. This leaves a clean hook for a future internal-access port.

Test Plan:
- Reset, then read addresses 0..15 with s_wen=0 -> s_rdata = 0 for every address.
- Write addr 7 = 5 (s_wen=1), next cycle write addr 8 = 6, then s_wen=0, addr=7 -> at the next edge s_rdata=5; then addr=8 -> at the next edge s_rdata=6.
- Write addr 3 = 0xDEADBEEF while holding addr=3 -> s_rdata is the old value (0) before the edge and 0xDEADBEEF after it.
- Back-to-back writes to all 16 addresses with value addr*0x01010101, then read all 16 -> each word matches and no aliasing occurs.
- Write addr 15 = 0xFFFFFFFF and addr 0 = 1, assert rst for one cycle with s_wen=1, addr=5, wdata=9 -> all words read 0 afterwards, including addr 5.
- s_wen=0 with varying s_addr and s_wdata over 10 cycles after writing addr 2 = 0x1234 -> addr 2 still reads 0x1234 and every other address reads 0.
